fir_ntap_stream: RTL and testbench
==================================

Name: fir_ntap_stream

Overview:
- Parametrised N-tap direct-form FIR filter; successor to the fixed 16-bit 3-tap FIR used in the ECG signal chain.
- Runtime-loadable coefficients; valid-qualified streaming input/output with a fixed 2-cycle pipeline.
- Output stage rounds and saturates.
- Optional approximate mode truncates product LSBs, so the approximate-arithmetic error of the filter can be measured against the exact path in the same instance.

Parameters:
- DATA_W, 16, signed width of x and y.
- COEF_W, 16, signed coefficient width (Q1.(COEF_W-1)).
- N_TAPS, 8, number of taps (≥2).
- OUT_SHIFT, 15, arithmetic right shift applied to the accumulator before saturation.
- APPROX_LSB, 4, number of product LSBs zeroed when approx_en=1 (0 disables approximation).

Ports:
- clk  in  1  clock, all logic on rising edge.
- rstN  in  1  synchronous active-low reset.
- x  in  DATA_W  signed input sample.
- in_valid  in  1  x valid this cycle.
- y  out  DATA_W  signed filtered output.
- out_valid  out  1  y valid this cycle.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(N_TAPS)  tap index k; 0 is the newest sample.
- coef_wdata  in  COEF_W  signed coefficient value.
- approx_en  in  1  1 = truncated products, 0 = exact.

Behaviour:
- Reset: sampled on a rising edge with rstN=0. Clears:
  - delay line to all zeros;
  - all coefficients to 0;
  - both pipeline stages;
  - out_valid to 0 and y to 0.
- Reset mid-stream: in-flight samples are discarded. out_valid is 0 on the edge after reset and stays 0 until new samples complete the pipeline. No partial outputs.
- Delay line d[0..N_TAPS-1] shifts only on edges where in_valid=1: d[0]<=x, d[k]<=d[k-1]. With in_valid=0 the line holds.
- Stage 1 (edge after the delay-line update):
  - p[k] = d[k]*c[k], full width DATA_W+COEF_W, signed.
  - If approx_en=1 and APPROX_LSB>0, the low APPROX_LSB bits of each p[k] are forced to 0, truncating toward −inf.
  - Registered with valid bit v1.
- Stage 2: computed as follows and registered into y with out_valid<=v1.
  - acc = Σp[k], width DATA_W+COEF_W+$clog2(N_TAPS); no overflow possible.
  - If OUT_SHIFT>0: r = (acc + 2^(OUT_SHIFT-1)) >>> OUT_SHIFT, i.e. round half up.
  - If OUT_SHIFT=0: r = acc, no rounding offset.
  - Saturation: y = r clipped to [−2^(DATA_W-1), 2^(DATA_W-1)−1].
- Latency: the sample accepted at edge E produces out_valid=1 at edge E+2, so y is visible in the cycle after E+2.
  - Throughput: 1 sample/cycle.
  - Gaps in in_valid propagate as gaps in out_valid, one-for-one.
- y holds its last value when out_valid=0.
- Coefficient writes:
  - coef_we=1 writes c[coef_addr]<=coef_wdata at the edge.
  - Stage 1 uses coefficient register contents at its own edge, so a write is visible to a product computed one or more edges after the write edge.
  - Writes are legal while streaming; no handshake; no read-back.
- Simultaneous write and reset: reset wins and the coefficient is 0.
- approx_en is sampled at stage 1 per sample. Toggling it mid-stream affects only products computed after the change.
- The filter has no stall or backpressure; downstream must accept every out_valid.

Test Plan:
- Impulse, defaults:
  - Stimulus: load c[k]=1000*(k+1) for k=0..7; stream x=16384 once, then zeros with continuous in_valid.
  - Required response: y = 500,1000,1500,...,4000, then 0.
  - Required timing: first out_valid 2 cycles after the impulse is accepted.
- Saturation:
  - Stimulus: all c=32767; x=32767 for 8+ valid cycles.
  - Required response: y saturates at 32767.
  - Stimulus: then x=−32768 sustained.
  - Required response: y = −32768.
  - Required: no wrap at any point.
- Bubbles:
  - Stimulus: c[0]=16384, c[1]=16384, rest 0; in_valid pattern 1,0,0,1,1,0,1 with x=2000,–,–,4000,−2000,–,6000.
  - Required response: out_valid pattern equals the in_valid pattern delayed by 2; y = 1000, 3000, 1000, 2000.
- Approximation, instance OUT_SHIFT=0, APPROX_LSB=4:
  - Stimulus: c[0]=1, rest 0; x=1234 with approx_en=0.
  - Required response: y=1234.
  - Stimulus: x=1234 with approx_en=1.
  - Required response: y=1232.
  - Stimulus: x=−1234 with approx_en=1.
  - Required response: y=−1248.
- Reset mid-stream:
  - Stimulus: run the impulse test; pull rstN low for 1 cycle after the 3rd output; then stream x=16384 without reloading coefficients.
  - Required response: out_valid=0 the edge after reset; all subsequent y=0 because coefficients were cleared.
- Coefficient write during streaming:
  - Stimulus: c[0]=16384, constant x=2000; write c[0]=8192 at edge W.
  - Required response: outputs from samples multiplied before W are 1000; from W+1 onward, 500.

Source files
------------

// File: rtl/fir_ntap_stream.sv
// N-tap direct-form FIR with runtime-loadable coefficients, two-stage pipeline
// (products, then sum/round/saturate) and optional truncated-product mode.
module fir_ntap_stream #(
    parameter int DATA_W     = 16,
    parameter int COEF_W     = 16,
    parameter int N_TAPS     = 8,
    parameter int OUT_SHIFT  = 15,
    parameter int APPROX_LSB = 4
) (
    input  logic                        clk,
    input  logic                        rstN,
    input  logic signed [DATA_W-1:0]    x,
    input  logic                        in_valid,
    output logic signed [DATA_W-1:0]    y,
    output logic                        out_valid,
    input  logic                        coef_we,
    input  logic [$clog2(N_TAPS)-1:0]   coef_addr,
    input  logic signed [COEF_W-1:0]    coef_wdata,
    input  logic                        approx_en
);

    localparam int ADDR_W  = $clog2(N_TAPS);
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int ACC_W   = PROD_W + $clog2(N_TAPS);
    localparam int HALF_SH = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

    localparam logic signed [ACC_W-1:0] Y_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] Y_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    function automatic logic signed [PROD_W-1:0] trunc_lsb(
        input logic signed [PROD_W-1:0] p,
        input logic                     en
    );
        logic signed [PROD_W-1:0] t;
        t = p;
        if (en && (APPROX_LSB > 0)) begin
            for (int b = 0; b < APPROX_LSB; b++) t[b] = 1'b0;
        end
        return t;
    endfunction

    // Round half up: add half an output LSB before the arithmetic shift.
    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] rnd;
        rnd = '0;
        if (OUT_SHIFT > 0) rnd[HALF_SH] = 1'b1;
        return (a + rnd) >>> OUT_SHIFT;
    endfunction

    function automatic logic signed [DATA_W-1:0] saturate(input logic signed [ACC_W-1:0] r);
        if (r > Y_MAX) return Y_MAX[DATA_W-1:0];
        if (r < Y_MIN) return Y_MIN[DATA_W-1:0];
        return r[DATA_W-1:0];
    endfunction

    logic signed [DATA_W-1:0] dly_q       [N_TAPS];
    logic signed [DATA_W-1:0] dly_d       [N_TAPS];
    logic signed [COEF_W-1:0] coef_q      [N_TAPS];
    logic signed [COEF_W-1:0] coef_d      [N_TAPS];
    logic signed [PROD_W-1:0] prod_p1_q   [N_TAPS];
    logic signed [PROD_W-1:0] prod_p1_d   [N_TAPS];
    logic signed [ACC_W-1:0]  acc_p1;
    logic signed [DATA_W-1:0] y_p2_q, y_p2_d;
    logic                     vld_p0_q, vld_p0_d;
    logic                     vld_p1_q, vld_p1_d;
    logic                     vld_p2_q, vld_p2_d;

    always_comb begin
        // Stage 0: delay line and coefficient bank
        dly_d    = dly_q;
        vld_p0_d = in_valid;
        if (in_valid) begin
            dly_d[0] = x;
            for (int k = 1; k < N_TAPS; k++) dly_d[k] = dly_q[k-1];
        end
        coef_d = coef_q;
        for (int k = 0; k < N_TAPS; k++) begin
            if (coef_we && (coef_addr == ADDR_W'(k))) coef_d[k] = coef_wdata;
        end

        // Stage 1: per-tap products
        vld_p1_d = vld_p0_q;
        for (int k = 0; k < N_TAPS; k++) begin
            prod_p1_d[k] = trunc_lsb(PROD_W'(dly_q[k]) * PROD_W'(coef_q[k]), approx_en);
        end

        // Stage 2: accumulate, round, saturate
        acc_p1 = '0;
        for (int k = 0; k < N_TAPS; k++) acc_p1 = acc_p1 + ACC_W'(prod_p1_q[k]);
        vld_p2_d = vld_p1_q;
        y_p2_d   = vld_p1_q ? saturate(round_shift(acc_p1)) : y_p2_q;
    end

    always_ff @(posedge clk) begin
        if (!rstN) begin
            for (int k = 0; k < N_TAPS; k++) begin
                dly_q[k]     <= '0;
                coef_q[k]    <= '0;
                prod_p1_q[k] <= '0;
            end
            vld_p0_q <= 1'b0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            y_p2_q   <= '0;
        end else begin
            dly_q     <= dly_d;
            coef_q    <= coef_d;
            prod_p1_q <= prod_p1_d;
            vld_p0_q  <= vld_p0_d;
            vld_p1_q  <= vld_p1_d;
            vld_p2_q  <= vld_p2_d;
            y_p2_q    <= y_p2_d;
        end
    end

    assign y         = y_p2_q;
    assign out_valid = vld_p2_q;

endmodule

// File: tb/tb_fir_ntap_stream.sv
// Directed bench for fir_ntap_stream: a default instance plus an
// OUT_SHIFT=0 / APPROX_LSB=4 instance sharing the same stimulus.
module tb_fir_ntap_stream;

    logic               clk = 1'b0;
    logic               rstN = 1'b0;
    logic signed [15:0] x = '0;
    logic               in_valid = 1'b0;
    logic               coef_we = 1'b0;
    logic [2:0]         coef_addr = '0;
    logic signed [15:0] coef_wdata = '0;
    logic               approx_en = 1'b0;
    logic signed [15:0] y, y_apx;
    logic               out_valid, out_valid_apx;

    int n_cmp = 0;
    int n_fail = 0;

    fir_ntap_stream u_dut (
        .clk(clk), .rstN(rstN), .x(x), .in_valid(in_valid),
        .y(y), .out_valid(out_valid),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .approx_en(approx_en)
    );

    fir_ntap_stream #(.OUT_SHIFT(0), .APPROX_LSB(4)) u_apx (
        .clk(clk), .rstN(rstN), .x(x), .in_valid(in_valid),
        .y(y_apx), .out_valid(out_valid_apx),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .approx_en(approx_en)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        in_valid = 1'b0;
        coef_we  = 1'b0;
        rstN     = 1'b0;
        step();
        rstN = 1'b1;
    endtask

    task automatic load_coef(input int k, input int val);
        coef_we    = 1'b1;
        coef_addr  = 3'(k);
        coef_wdata = 16'(val);
        step();
        coef_we = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        step();
        step();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_vld got=%0b want=0", out_valid); end
        n_cmp++;
        if (y !== 16'sd0) begin n_fail++; $display("FAIL reset_y got=%0d want=0", y); end
        n_cmp++;
        if (out_valid_apx !== 1'b0) begin n_fail++; $display("FAIL reset_vld_apx got=%0b want=0", out_valid_apx); end
        n_cmp++;
        if (y_apx !== 16'sd0) begin n_fail++; $display("FAIL reset_y_apx got=%0d want=0", y_apx); end
        rstN = 1'b1;
    endtask

    task automatic test_impulse();
        int exp;
        apply_reset();
        for (int k = 0; k < 8; k++) load_coef(k, 1000 * (k + 1));
        for (int i = 0; i < 14; i++) begin
            in_valid = (i < 12);
            x = 16'(i == 0 ? 16384 : 0);
            step();
            if (i < 2) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin n_fail++; $display("FAIL imp_latency i=%0d got=%0b want=0", i, out_valid); end
            end else begin
                exp = (i - 2 < 8) ? 500 * (i - 1) : 0;
                n_cmp++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL imp_vld i=%0d got=%0b want=1", i, out_valid); end
                n_cmp++;
                if (y !== exp) begin n_fail++; $display("FAIL imp_y i=%0d got=%0d want=%0d", i, y, exp); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_saturation();
        int exp;
        int m;
        apply_reset();
        for (int k = 0; k < 8; k++) load_coef(k, 32767);
        for (int i = 0; i < 26; i++) begin
            in_valid = (i < 24);
            x = 16'(i < 12 ? 32767 : -32768);
            step();
            if (i >= 2) begin
                m = i - 2 - 11;
                if (i - 2 == 0)      exp = 32766;
                else if (m <= 0)     exp = 32767;
                else if (m <= 3)     exp = 32767;
                else if (m == 4)     exp = -4;
                else                 exp = -32768;
                n_cmp++;
                if (y !== exp) begin n_fail++; $display("FAIL sat_y j=%0d got=%0d want=%0d", i - 2, y, exp); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_bubbles();
        logic iv   [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        int   xs   [9] = '{2000, 0, 0, 4000, -2000, 0, 6000, 0, 0};
        logic ev   [9] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        int   ey   [9] = '{0, 0, 1000, 1000, 1000, 3000, 1000, 1000, 2000};
        apply_reset();
        load_coef(0, 16384);
        load_coef(1, 16384);
        for (int i = 0; i < 9; i++) begin
            in_valid = iv[i];
            x = 16'(xs[i]);
            step();
            n_cmp++;
            if (out_valid !== ev[i]) begin n_fail++; $display("FAIL bub_vld i=%0d got=%0b want=%0b", i, out_valid, ev[i]); end
            n_cmp++;
            if (y !== ey[i]) begin n_fail++; $display("FAIL bub_y i=%0d got=%0d want=%0d", i, y, ey[i]); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_approx();
        int xs [3] = '{1234, 1234, -1234};
        logic ae [3] = '{1'b0, 1'b1, 1'b1};
        int ey [3] = '{1234, 1232, -1248};
        apply_reset();
        load_coef(0, 1);
        for (int s = 0; s < 3; s++) begin
            approx_en = ae[s];
            x = 16'(xs[s]);
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            step();
            step();
            n_cmp++;
            if (out_valid_apx !== 1'b1) begin n_fail++; $display("FAIL apx_vld s=%0d got=%0b want=1", s, out_valid_apx); end
            n_cmp++;
            if (y_apx !== ey[s]) begin n_fail++; $display("FAIL apx_y s=%0d got=%0d want=%0d", s, y_apx, ey[s]); end
        end
        approx_en = 1'b0;
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        for (int k = 0; k < 8; k++) load_coef(k, 1000 * (k + 1));
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            x = 16'(i == 0 ? 16384 : 0);
            step();
        end
        n_cmp++;
        if (y !== 16'sd1500) begin n_fail++; $display("FAIL mid_pre_y got=%0d want=1500", y); end
        rstN = 1'b0;
        step();
        rstN = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_vld got=%0b want=0", out_valid); end
        n_cmp++;
        if (y !== 16'sd0) begin n_fail++; $display("FAIL mid_rst_y got=%0d want=0", y); end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            x = 16'sd16384;
            step();
            n_cmp++;
            if (out_valid !== (i >= 2)) begin n_fail++; $display("FAIL mid_vld i=%0d got=%0b want=%0b", i, out_valid, (i >= 2)); end
            n_cmp++;
            if (y !== 16'sd0) begin n_fail++; $display("FAIL mid_y i=%0d got=%0d want=0", i, y); end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_coef_write();
        int exp;
        apply_reset();
        load_coef(0, 16384);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            x = 16'sd2000;
            coef_we = (i == 5);
            coef_addr = 3'd0;
            coef_wdata = 16'sd8192;
            step();
            coef_we = 1'b0;
            if (i >= 2) begin
                exp = (i <= 6) ? 1000 : 500;
                n_cmp++;
                if (out_valid !== 1'b1) begin n_fail++; $display("FAIL cw_vld i=%0d got=%0b want=1", i, out_valid); end
                n_cmp++;
                if (y !== exp) begin n_fail++; $display("FAIL cw_y i=%0d got=%0d want=%0d", i, y, exp); end
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_impulse();
        test_saturation();
        test_bubbles();
        test_approx();
        test_reset_midstream();
        test_coef_write();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
